// File: rtl/alarm_ring_sched_pkg.sv
// Shared alarm/time definitions: time field slices, wrap limits and ring FSM encoding.
package alarm_ring_sched_pkg;
  localparam int H_MSB = 16;
  localparam int H_LSB = 12;
  localparam int M_MSB = 11;
  localparam int M_LSB = 6;
  localparam int S_MSB = 5;
  localparam int S_LSB = 0;

  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RINGING  = 2'd1,
    SNOOZING = 2'd2,
    DONE     = 2'd3
  } ring_state_e;
endpackage

// File: rtl/alarm_ring_sched_hm_add_wrap.sv
// H:M plus minutes, wrapping 23:59 -> 00:00. Combinational; add_min must be 0..59.
module hm_add_wrap
  import alarm_ring_sched_pkg::*;
(
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] add_min,
  output logic [4:0] sum_hour,
  output logic [5:0] sum_min
);

  logic [6:0] min_sum;

  always_comb begin
    min_sum  = {1'b0, minute} + {1'b0, add_min};
    sum_hour = hour;
    sum_min  = min_sum[5:0];
    // add_min <= 59 means at most one carry into the hour
    if (min_sum > 7'(MAX_MIN)) begin
      sum_min  = 6'(min_sum - 7'(MAX_MIN + 1));
      sum_hour = (hour == 5'(MAX_HOUR)) ? 5'd0 : hour + 5'd1;
    end
  end

endmodule

// File: rtl/alarm_ring_sched.sv
// Alarm ring scheduler: match detect, ring / snooze / stop sequencing, piezo beep gate.
// Optional build macro ALARM_ESCALATE_EN: continuous tone after ESCALATE_S ringing seconds.
module alarm_ring_sched
  import alarm_ring_sched_pkg::*;
#(
  parameter int SNOOZE_MIN   = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 60,
  parameter int ESCALATE_S   = 20
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SEC_TICK,
  input  logic        ALARM_ENABLE,
  input  logic        SETTING,
  input  logic [16:0] CURRENT_TIME,
  input  logic [16:0] ALARM_TIME,
  input  logic        KEY_SNOOZE,
  input  logic        KEY_STOP,
  output logic        ALARM_DOING,
  output logic        PIEZO_GATE,
  output logic        SNOOZE_ACTIVE,
  output logic [1:0]  SNOOZE_CNT,
  output logic [16:0] NEXT_RING
);

  // One counter width covers both the ring timeout and the escalate threshold
  localparam int CNT_MAX = (RING_TIMEOUT > ESCALATE_S) ? RING_TIMEOUT : ESCALATE_S;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ring_state_e       state_q, state_d;
  logic              key_stop_r, key_stop_h, key_snz_r, key_snz_h;
  logic              stop_press, snz_press, snooze_req, time_match;
  logic [CNT_W-1:0]  ring_cnt_q, ring_cnt_d;
  logic              gate_q, gate_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [16:0]       next_ring_q, next_ring_d;
  logic [4:0]        snz_hour;
  logic [5:0]        snz_min;
`ifdef ALARM_ESCALATE_EN
  logic [CNT_W-1:0]  esc_cnt_q, esc_cnt_d;
`endif

  hm_add_wrap u_hm_add (
    .hour     (CURRENT_TIME[H_MSB:H_LSB]),
    .minute   (CURRENT_TIME[M_MSB:M_LSB]),
    .add_min  (6'(SNOOZE_MIN)),
    .sum_hour (snz_hour),
    .sum_min  (snz_min)
  );

  // Keys reset to 1 so a key held through reset never reads as a press
  always_ff @(posedge CLK) begin
    if (RESET) begin
      key_stop_r <= 1'b1;
      key_stop_h <= 1'b1;
      key_snz_r  <= 1'b1;
      key_snz_h  <= 1'b1;
    end else begin
      key_stop_r <= KEY_STOP;
      key_stop_h <= key_stop_r;
      key_snz_r  <= KEY_SNOOZE;
      key_snz_h  <= key_snz_r;
    end
  end

  assign stop_press = key_stop_r & ~key_stop_h;
  assign snz_press  = key_snz_r & ~key_snz_h;
  assign time_match = (CURRENT_TIME == ALARM_TIME);
  assign snooze_req = snz_press | (ring_cnt_q == CNT_W'(RING_TIMEOUT));

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ring_cnt_d  = ring_cnt_q;
    gate_d      = gate_q;
    cnt_d       = cnt_q;
    next_ring_d = next_ring_q;
`ifdef ALARM_ESCALATE_EN
    esc_cnt_d   = esc_cnt_q;
`endif
    if (!ALARM_ENABLE) begin
      state_d     = IDLE;
      ring_cnt_d  = '0;
      gate_d      = 1'b0;
      cnt_d       = '0;
      next_ring_d = '0;
`ifdef ALARM_ESCALATE_EN
      esc_cnt_d   = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!SETTING && time_match) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
            gate_d     = 1'b1;
`ifdef ALARM_ESCALATE_EN
            esc_cnt_d  = '0;
`endif
          end
        end
        RINGING: begin
          if (stop_press) begin
            state_d = DONE;
            gate_d  = 1'b0;
            cnt_d   = '0;
          end else if (snooze_req) begin
            gate_d = 1'b0;
            if (cnt_q < 2'(MAX_SNOOZE)) begin
              state_d     = SNOOZING;
              cnt_d       = cnt_q + 2'd1;
              next_ring_d = {snz_hour, snz_min, CURRENT_TIME[S_MSB:S_LSB]};
            end else begin
              state_d = DONE;
              cnt_d   = '0;
            end
          end else if (SEC_TICK) begin
            ring_cnt_d = ring_cnt_q + CNT_W'(1);
`ifdef ALARM_ESCALATE_EN
            if (esc_cnt_q != CNT_W'(ESCALATE_S)) esc_cnt_d = esc_cnt_q + CNT_W'(1);
            gate_d = (esc_cnt_d == CNT_W'(ESCALATE_S)) ? 1'b1 : ~gate_q;
`else
            gate_d = ~gate_q;
`endif
          end
        end
        SNOOZING: begin
          if (stop_press) begin
            state_d = DONE;
            cnt_d   = '0;
          end else if (!SETTING && CURRENT_TIME == next_ring_q) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
            gate_d     = 1'b1;
`ifdef ALARM_ESCALATE_EN
            esc_cnt_d  = '0;
`endif
          end
        end
        DONE: begin
          cnt_d = '0;
          // hold off until the matching minute has passed
          if (CURRENT_TIME[H_MSB:M_LSB] != ALARM_TIME[H_MSB:M_LSB]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ring_cnt_q  <= '0;
      gate_q      <= 1'b0;
      cnt_q       <= '0;
      next_ring_q <= '0;
`ifdef ALARM_ESCALATE_EN
      esc_cnt_q   <= '0;
`endif
    end else begin
      ring_cnt_q  <= ring_cnt_d;
      gate_q      <= gate_d;
      cnt_q       <= cnt_d;
      next_ring_q <= next_ring_d;
`ifdef ALARM_ESCALATE_EN
      esc_cnt_q   <= esc_cnt_d;
`endif
    end
  end

  assign ALARM_DOING   = (state_q == RINGING);
  assign SNOOZE_ACTIVE = (state_q == SNOOZING);
  assign PIEZO_GATE    = gate_q;
  assign SNOOZE_CNT    = cnt_q;
  assign NEXT_RING     = (state_q == SNOOZING) ? next_ring_q : ALARM_TIME;

endmodule

// File: tb/tb_alarm_ring_sched.sv
// Directed bench for alarm_ring_sched: ring, snooze wrap, snooze limit, timeout, stop, enable drop.
module tb_alarm_ring_sched;

  logic        CLK = 1'b0;
  logic        RESET, SEC_TICK, ALARM_ENABLE, SETTING, KEY_SNOOZE, KEY_STOP;
  logic [16:0] CURRENT_TIME, ALARM_TIME;
  logic        ALARM_DOING, PIEZO_GATE, SNOOZE_ACTIVE;
  logic [1:0]  SNOOZE_CNT;
  logic [16:0] NEXT_RING;

  int n_assert = 0;
  int n_fail   = 0;

  alarm_ring_sched dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .SEC_TICK      (SEC_TICK),
    .ALARM_ENABLE  (ALARM_ENABLE),
    .SETTING       (SETTING),
    .CURRENT_TIME  (CURRENT_TIME),
    .ALARM_TIME    (ALARM_TIME),
    .KEY_SNOOZE    (KEY_SNOOZE),
    .KEY_STOP      (KEY_STOP),
    .ALARM_DOING   (ALARM_DOING),
    .PIEZO_GATE    (PIEZO_GATE),
    .SNOOZE_ACTIVE (SNOOZE_ACTIVE),
    .SNOOZE_CNT    (SNOOZE_CNT),
    .NEXT_RING     (NEXT_RING)
  );

  always #5 CLK = ~CLK;

  function automatic logic [16:0] t(input int h, input int m, input int s);
    logic [4:0] hh;
    logic [5:0] mm, ss;
    hh = 5'(h);
    mm = 6'(m);
    ss = 6'(s);
    return {hh, mm, ss};
  endfunction

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Key goes through a sync stage, so the state reacts at the second edge
  task automatic press(input logic stop, input logic snz);
    KEY_STOP   = stop;
    KEY_SNOOZE = snz;
    cyc();
    cyc();
    KEY_STOP   = 1'b0;
    KEY_SNOOZE = 1'b0;
  endtask

  task automatic tick(input logic [16:0] tm);
    CURRENT_TIME = tm;
    SEC_TICK     = 1'b1;
    cyc();
    SEC_TICK     = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; SEC_TICK = 1'b0; ALARM_ENABLE = 1'b1; SETTING = 1'b0;
    KEY_SNOOZE = 1'b0; KEY_STOP = 1'b1;
    ALARM_TIME = t(7, 30, 0); CURRENT_TIME = t(7, 30, 0);
    cyc(); cyc();
    check("rst_doing", ALARM_DOING, 1'b0);
    check("rst_gate", PIEZO_GATE, 1'b0);
    check("rst_snz", SNOOZE_ACTIVE, 1'b0);
    check("rst_cnt", SNOOZE_CNT, 2'd0);
    check("rst_next", NEXT_RING, t(7, 30, 0));

    // Stop key held through reset must not count as a press
    RESET = 1'b0;
    cyc();
    check("post_rst_ring", ALARM_DOING, 1'b1);
    cyc();
    check("held_stop_no_press", ALARM_DOING, 1'b1);

    // Enable dropped mid-ring
    KEY_STOP = 1'b0; ALARM_ENABLE = 1'b0;
    cyc();
    check("en_drop_doing", ALARM_DOING, 1'b0);
    check("en_drop_gate", PIEZO_GATE, 1'b0);
    check("en_drop_cnt", SNOOZE_CNT, 2'd0);

    // Basic ring and beep toggle
    ALARM_ENABLE = 1'b1; CURRENT_TIME = t(7, 29, 59);
    cyc();
    check("pre_match", ALARM_DOING, 1'b0);
    tick(t(7, 30, 0));
    check("ring_doing", ALARM_DOING, 1'b1);
    check("ring_gate_on", PIEZO_GATE, 1'b1);
    tick(t(7, 30, 1));
    check("gate_toggle1", PIEZO_GATE, 1'b0);
    tick(t(7, 30, 2));
    check("gate_toggle2", PIEZO_GATE, 1'b1);
    SETTING = 1'b1;
    cyc();
    check("setting_keeps_ring", ALARM_DOING, 1'b1);
    SETTING = 1'b0;

    // Stop and snooze together: stop wins
    CURRENT_TIME = t(7, 30, 5);
    press(1'b1, 1'b1);
    check("both_doing", ALARM_DOING, 1'b0);
    check("both_snz", SNOOZE_ACTIVE, 1'b0);
    check("both_cnt", SNOOZE_CNT, 2'd0);
    check("both_gate", PIEZO_GATE, 1'b0);
    CURRENT_TIME = t(7, 30, 0);
    cyc(); cyc(); cyc();
    check("no_retrigger", ALARM_DOING, 1'b0);
    CURRENT_TIME = t(7, 31, 0);
    cyc();
    CURRENT_TIME = t(7, 30, 0);
    cyc();
    check("rearm_after_minute", ALARM_DOING, 1'b1);

    // Snooze across midnight, then up to the snooze limit
    CURRENT_TIME = t(23, 58, 10);
    press(1'b0, 1'b1);
    check("snz1_active", SNOOZE_ACTIVE, 1'b1);
    check("snz1_cnt", SNOOZE_CNT, 2'd1);
    check("snz1_doing", ALARM_DOING, 1'b0);
    check("snz1_gate", PIEZO_GATE, 1'b0);
    check("snz1_next_wrap", NEXT_RING, t(0, 3, 10));
    ALARM_TIME = t(8, 0, 0);
    cyc();
    check("snz_keeps_old_next", NEXT_RING, t(0, 3, 10));
    CURRENT_TIME = t(0, 3, 9);
    cyc();
    check("snz_early", ALARM_DOING, 1'b0);
    CURRENT_TIME = t(0, 3, 10); SETTING = 1'b1;
    cyc();
    check("snz_setting_blocks", ALARM_DOING, 1'b0);
    SETTING = 1'b0;
    cyc();
    check("rering1_doing", ALARM_DOING, 1'b1);
    check("rering1_gate", PIEZO_GATE, 1'b1);
    check("rering1_snz", SNOOZE_ACTIVE, 1'b0);
    check("rering1_cnt", SNOOZE_CNT, 2'd1);
    check("rering1_next", NEXT_RING, t(8, 0, 0));
    press(1'b0, 1'b1);
    check("snz2_cnt", SNOOZE_CNT, 2'd2);
    check("snz2_next", NEXT_RING, t(0, 8, 10));
    CURRENT_TIME = t(0, 8, 10);
    cyc();
    check("rering2", ALARM_DOING, 1'b1);
    press(1'b0, 1'b1);
    check("snz3_cnt", SNOOZE_CNT, 2'd3);
    check("snz3_next", NEXT_RING, t(0, 13, 10));
    CURRENT_TIME = t(0, 13, 10);
    cyc();
    check("rering3", ALARM_DOING, 1'b1);
    press(1'b0, 1'b1);
    check("snz4_doing", ALARM_DOING, 1'b0);
    check("snz4_snz", SNOOZE_ACTIVE, 1'b0);
    check("snz4_cnt", SNOOZE_CNT, 2'd0);
    CURRENT_TIME = t(0, 18, 10);
    cyc(); cyc();
    check("snz4_no_rering", ALARM_DOING, 1'b0);

    // Unanswered ring: auto-snooze after 60 ticks
    ALARM_TIME = t(7, 30, 0); CURRENT_TIME = t(7, 30, 0);
    cyc();
    check("to_ring", ALARM_DOING, 1'b1);
    for (int i = 1; i <= 60; i++) begin
      tick((i < 60) ? t(7, 30, i) : t(7, 31, 0));
      if (i == 60) check("to_boundary_still_ring", ALARM_DOING, 1'b1);
      cyc();
      if (i == 59) begin
        check("to_59_doing", ALARM_DOING, 1'b1);
        check("to_59_gate", PIEZO_GATE, 1'b0);
      end
    end
    check("to_snz_active", SNOOZE_ACTIVE, 1'b1);
    check("to_snz_cnt", SNOOZE_CNT, 2'd1);
    check("to_next", NEXT_RING, t(7, 36, 0));
    CURRENT_TIME = t(7, 36, 0);
    cyc();
    check("to_rering", ALARM_DOING, 1'b1);
    press(1'b1, 1'b0);
    check("to_stop_doing", ALARM_DOING, 1'b0);
    check("to_stop_cnt", SNOOZE_CNT, 2'd0);
    CURRENT_TIME = t(12, 0, 0);
    cyc(); cyc();
    check("to_quiet", ALARM_DOING, 1'b0);
    CURRENT_TIME = t(7, 30, 0);
    cyc();
    check("next_day_ring", ALARM_DOING, 1'b1);
    ALARM_ENABLE = 1'b0;
    cyc();
    check("final_off_doing", ALARM_DOING, 1'b0);
    check("final_off_gate", PIEZO_GATE, 1'b0);
    check("final_off_next", NEXT_RING, t(7, 30, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
